// File: rtl/fdiv_mul.sv
// fdiv_mul: multiplies the dividend by the reciprocal from finv (y = x1 * inv),
// delaying x1 to line up with inv. Truncating single-precision multiply, flush-to-zero, clamp to Inf.
module fdiv_mul #(
    parameter int DELAY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] x1,
    input  logic [31:0] inv,
    output logic        out_valid,
    output logic [31:0] y
);
    logic [DELAY-1:0] dv;
    logic [31:0]      dx [DELAY];
    logic             vd;
    logic [31:0]      xd;
    logic [23:0]      ma, mb;
    logic             v1, s1, z1;
    logic signed [9:0] e1;
    logic [24:0]      p1;
    logic             v2, s2, z2;
    logic signed [9:0] e2;
    logic [22:0]      m2;
    logic [31:0]      y_next;

    assign vd = dv[DELAY-1];
    assign xd = dx[DELAY-1];
    assign ma = {1'b1, xd[22:0]};
    assign mb = {1'b1, inv[22:0]};

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            dv        <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
        end else begin
            dv[0] <= in_valid;
            for (int i = 1; i < DELAY; i++) dv[i] <= dv[i-1];
            v1        <= vd;
            v2        <= v1;
            out_valid <= v2;
            if (v2) y <= y_next;
        end

    // Only product bits [47:23] can reach the truncated mantissa, so the low bits are dropped at capture.
    always_ff @(posedge clk) begin
        dx[0] <= x1;
        for (int i = 1; i < DELAY; i++) dx[i] <= dx[i-1];
        if (vd) begin
            s1 <= xd[31] ^ inv[31];
            e1 <= 10'(xd[30:23]) + 10'(inv[30:23]) - 10'd127;
            p1 <= 25'((48'(ma) * 48'(mb)) >> 23);
            z1 <= (xd[30:23] == 8'd0) || (inv[30:23] == 8'd0);
        end
        if (v1) begin
            s2 <= s1;
            z2 <= z1;
            e2 <= e1 + {9'd0, p1[24]};
            m2 <= p1[24] ? p1[23:1] : p1[22:0];
        end
    end

    always_comb
        y_next = (z2 || e2 <= 10'sd0) ? {s2, 31'h0}
               : (e2 >= 10'sd255)     ? {s2, 8'hFF, 23'h0}
               :                        {s2, e2[7:0], m2};
endmodule

// File: tb/tb_fdiv_mul.sv
// tb_fdiv_mul: directed vectors for fdiv_mul, with cycle-exact latency,
// streaming and mid-flight reset sequences.
module tb_fdiv_mul;
    localparam logic [31:0] JUNK = 32'h7F7FFFFF;
    localparam int NV = 16;

    typedef struct {
        logic [31:0] x1;
        logic [31:0] inv;
        logic [31:0] y;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] x1 = '0;
    logic [31:0] inv = '0;
    logic        out_valid;
    logic [31:0] y;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_y = '0;
    vec_t        tv [NV];
    vec_t        so [16];
    bit          sv [16];

    fdiv_mul #(.DELAY(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .x1       (x1),
        .inv      (inv),
        .out_valid(out_valid),
        .y        (y)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drives sv/so as one op per cycle (inv DELAY cycles later) and checks every output cycle.
    task automatic run_seq(input int n, input string nm);
        int  k;
        bit  ev;
        for (int c = 0; c < n + 7; c++) begin
            k        = c - 3;
            in_valid = (c < n) ? sv[c] : 1'b0;
            x1       = (c < n) ? so[c].x1 : JUNK;
            inv      = (k >= 0 && k < n) ? (sv[k] ? so[k].inv : JUNK) : JUNK;
            @(posedge clk);
            #1;
            k  = c - 5;
            ev = 1'b0;
            if (k >= 0 && k < n) begin
                if (sv[k]) begin
                    ev    = 1'b1;
                    exp_y = so[k].y;
                end
            end
            chk($sformatf("%s out_valid c%0d", nm, c), {31'b0, out_valid}, {31'b0, ev});
            chk($sformatf("%s y c%0d", nm, c), y, exp_y);
        end
    endtask

    initial begin
        tv[0]  = '{32'h40C00000, 32'h3F000000, 32'h40400000};
        tv[1]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000};
        tv[2]  = '{32'hC0000000, 32'h3F000000, 32'hBF800000};
        tv[3]  = '{32'h00000000, 32'h40490FDB, 32'h00000000};
        tv[4]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000};
        tv[5]  = '{32'h00800000, 32'h3F000000, 32'h00000000};
        tv[6]  = '{32'h40400000, 32'h3E800000, 32'h3F400000};
        tv[7]  = '{32'hBFC00000, 32'hBFC00000, 32'h40100000};
        tv[8]  = '{32'h3F800000, 32'h00000000, 32'h00000000};
        tv[9]  = '{32'h80000000, 32'h3F800000, 32'h80000000};
        tv[10] = '{32'h3FC00001, 32'h3FC00000, 32'h40100000};
        tv[11] = '{32'h7F800000, 32'h3F000000, 32'h7F000000};
        tv[12] = '{32'h7F400000, 32'h3F400000, 32'h7F100000};
        tv[13] = '{32'h7F400000, 32'h3FC00000, 32'h7F800000};
        tv[14] = '{32'h00800000, 32'h3F800000, 32'h00800000};
        tv[15] = '{32'h00C00000, 32'h3F400000, 32'h00900000};

        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {31'b0, out_valid}, 32'h0);
        chk("reset y", y, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            sv[0] = 1'b1;
            so[0] = tv[i];
            run_seq(1, $sformatf("vec%0d", i));
        end

        sv[0] = 1'b1; so[0] = tv[0];
        sv[1] = 1'b1; so[1] = tv[1];
        sv[2] = 1'b1; so[2] = tv[2];
        sv[3] = 1'b1; so[3] = tv[6];
        sv[4] = 1'b0; so[4] = '{JUNK, JUNK, JUNK};
        sv[5] = 1'b1; so[5] = tv[12];
        sv[6] = 1'b1; so[6] = tv[15];
        run_seq(7, "stream");

        in_valid = 1'b1;
        x1       = 32'h40C00000;
        inv      = JUNK;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x1       = JUNK;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        inv = 32'h3F000000;
        #1;
        chk("midrst async out_valid", {31'b0, out_valid}, 32'h0);
        chk("midrst async y", y, 32'h0);
        @(posedge clk); #1;
        chk("midrst held out_valid", {31'b0, out_valid}, 32'h0);
        @(posedge clk); #1;
        rst   = 1'b0;
        exp_y = '0;
        sv[0] = 1'b1;
        so[0] = tv[1];
        run_seq(1, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
